// File: rtl/soc_ram_sys_if.sv
// System RAM bus bundle: three write sources, the read port and the write-trace bus.
interface soc_ram_sys_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 128
);
    logic              prog_wen;
    logic [ADDR_W+1:0] prog_waddr;
    logic [31:0]       prog_wdata;
    logic              uart2sys_en;
    logic [ADDR_W-1:0] uart2sys_addr;
    logic [DATA_W-1:0] uart2sys_data;
    logic              sys_wren;
    logic [ADDR_W-1:0] sys_final_addr;
    logic [DATA_W-1:0] sys_data;
    logic [DATA_W-1:0] sysRAM_data;
    logic              ram_wen;
    logic [1:0]        biu_pad_htrans;
    logic              biu_pad_hwrite;
    logic [31:0]       biu_pad_haddr;
    logic [DATA_W-1:0] biu_pad_hwdata;

    modport master (
        output prog_wen, prog_waddr, prog_wdata,
        output uart2sys_en, uart2sys_addr, uart2sys_data,
        output sys_wren, sys_final_addr, sys_data,
        input  sysRAM_data, ram_wen, biu_pad_htrans, biu_pad_hwrite,
        input  biu_pad_haddr, biu_pad_hwdata
    );

    modport slave (
        input  prog_wen, prog_waddr, prog_wdata,
        input  uart2sys_en, uart2sys_addr, uart2sys_data,
        input  sys_wren, sys_final_addr, sys_data,
        output sysRAM_data, ram_wen, biu_pad_htrans, biu_pad_hwrite,
        output biu_pad_haddr, biu_pad_hwdata
    );
endinterface

// File: rtl/soc_ram_sys.sv
// SoC system RAM: 128-bit line memory, fixed-priority write arbitration
// (UART > system > program loader), registered read-first read port and
// a registered AHB-style trace of every committed write.
module soc_ram_sys #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 128
) (
    input  logic         clk,
    input  logic         rst_b,
    soc_ram_sys_if.slave bus
);
    localparam int unsigned LINES  = 1 << ADDR_W;
    localparam int unsigned HADDR_W = 32;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

    logic [DATA_W-1:0] mem [LINES];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_line;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] prog_line;
    logic [DATA_W-1:0] prog_old;

    // Pick the winning write source and build the line value it commits.
    always_comb begin
        wr_en     = 1'b0;
        wr_line   = '0;
        wr_data   = '0;
        prog_line = bus.prog_waddr[ADDR_W+1:2];
        prog_old  = mem[prog_line];
        if (bus.uart2sys_en) begin
            wr_en   = 1'b1;
            wr_line = bus.uart2sys_addr;
            wr_data = bus.uart2sys_data;
        end else if (bus.sys_wren) begin
            wr_en   = 1'b1;
            wr_line = bus.sys_final_addr;
            wr_data = bus.sys_data;
        end else if (bus.prog_wen) begin
            wr_en   = 1'b1;
            wr_line = prog_line;
            wr_data = prog_old;
            case (bus.prog_waddr[1:0])
                2'd0:    wr_data[31:0]   = bus.prog_wdata;
                2'd1:    wr_data[63:32]  = bus.prog_wdata;
                2'd2:    wr_data[95:64]  = bus.prog_wdata;
                default: wr_data[127:96] = bus.prog_wdata;
            endcase
        end
    end

    // Memory array; a write coinciding with reset is dropped, contents are never cleared.
    always_ff @(posedge clk) begin
        if (wr_en && rst_b) begin
            mem[wr_line] <= wr_data;
        end
    end

    // Registered read port, read-first on a same-line collision.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bus.sysRAM_data <= '0;
        end else begin
            bus.sysRAM_data <= mem[bus.sys_final_addr];
        end
    end

    // Write trace: one NONSEQ beat per committed write; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bus.ram_wen        <= 1'b0;
            bus.biu_pad_htrans <= HTRANS_IDLE;
            bus.biu_pad_hwrite <= 1'b0;
            bus.biu_pad_haddr  <= '0;
            bus.biu_pad_hwdata <= '0;
        end else begin
            bus.ram_wen        <= wr_en;
            bus.biu_pad_htrans <= wr_en ? HTRANS_NONSEQ : HTRANS_IDLE;
            bus.biu_pad_hwrite <= wr_en;
            if (wr_en) begin
                bus.biu_pad_haddr  <= HADDR_W'({wr_line, 4'b0000});
                bus.biu_pad_hwdata <= wr_data;
            end
        end
    end
endmodule

// File: tb/tb_soc_ram_sys.sv
// Self-checking bench for soc_ram_sys: directed scenarios plus randomized
// traffic checked against an associative-array line memory model.
module tb_soc_ram_sys;
    logic clk;
    logic rst_b;

    soc_ram_sys_if #(.ADDR_W(20), .DATA_W(128)) bif ();

    soc_ram_sys #(.ADDR_W(20), .DATA_W(128)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bif)
    );

    int checks   = 0;
    int failures = 0;

    logic [127:0] model [logic [19:0]];
    logic [31:0]  exp_haddr;
    logic [127:0] exp_hwdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bif.prog_wen       = 1'b0;
        bif.uart2sys_en    = 1'b0;
        bif.sys_wren       = 1'b0;
    endtask

    // One clock: predict from current inputs, advance, compare all outputs.
    task automatic cycle(input string tag);
        logic [127:0] exp_rd;
        logic [127:0] wd;
        logic [19:0]  wl;
        bit           rd_known;
        bit           w;
        int           lane;
        rd_known = model.exists(bif.sys_final_addr);
        exp_rd   = rd_known ? model[bif.sys_final_addr] : '0;
        w  = 1'b0;
        wl = '0;
        wd = '0;
        if (bif.uart2sys_en) begin
            w = 1'b1; wl = bif.uart2sys_addr; wd = bif.uart2sys_data;
        end else if (bif.sys_wren) begin
            w = 1'b1; wl = bif.sys_final_addr; wd = bif.sys_data;
        end else if (bif.prog_wen) begin
            w    = 1'b1;
            wl   = 20'(bif.prog_waddr / 4);
            lane = int'(bif.prog_waddr % 4);
            wd   = model.exists(wl) ? model[wl] : '0;
            wd[lane*32 +: 32] = bif.prog_wdata;
        end
        @(posedge clk);
        #1;
        if (!rst_b) begin
            exp_haddr  = '0;
            exp_hwdata = '0;
            chk({tag, ":rd_rst"}, bif.sysRAM_data, '0);
            chk({tag, ":wen"}, 128'(bif.ram_wen), '0);
            chk({tag, ":htrans"}, 128'(bif.biu_pad_htrans), '0);
            chk({tag, ":hwrite"}, 128'(bif.biu_pad_hwrite), '0);
        end else begin
            if (w) begin
                model[wl]  = wd;
                exp_haddr  = 32'(wl) * 16;
                exp_hwdata = wd;
            end
            if (rd_known) chk({tag, ":rd"}, bif.sysRAM_data, exp_rd);
            chk({tag, ":wen"}, 128'(bif.ram_wen), 128'(w));
            chk({tag, ":htrans"}, 128'(bif.biu_pad_htrans), w ? 128'd2 : 128'd0);
            chk({tag, ":hwrite"}, 128'(bif.biu_pad_hwrite), 128'(w));
        end
        chk({tag, ":haddr"}, 128'(bif.biu_pad_haddr), 128'(exp_haddr));
        chk({tag, ":hwdata"}, bif.biu_pad_hwdata, exp_hwdata);
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] old_line;
        rst_b              = 1'b0;
        idle_inputs();
        bif.prog_waddr     = '0;
        bif.prog_wdata     = '0;
        bif.uart2sys_addr  = '0;
        bif.uart2sys_data  = '0;
        bif.sys_final_addr = '0;
        bif.sys_data       = '0;
        exp_haddr          = '0;
        exp_hwdata         = '0;

        // T1 reset: all outputs zero
        @(negedge clk);
        cycle("t1_reset");
        chk("t1_rd", bif.sysRAM_data, '0);
        rst_b = 1'b1;
        cycle("t1_idle");

        // T2 UART writes, 10 beats to line 2
        bif.uart2sys_en    = 1'b1;
        bif.uart2sys_addr  = 20'h00002;
        bif.uart2sys_data  = 128'h7;
        bif.sys_final_addr = 20'h00002;
        for (int i = 0; i < 10; i++) cycle("t2_uart");
        chk("t2_haddr", 128'(bif.biu_pad_haddr), 128'h20);
        idle_inputs();
        cycle("t2_read");
        chk("t2_rd7", bif.sysRAM_data, 128'h7);

        // T3 system overwrite for 100 cycles
        bif.sys_wren = 1'b1;
        bif.sys_data = 128'h8;
        for (int i = 0; i < 100; i++) cycle("t3_sys");
        idle_inputs();
        cycle("t3_read");
        chk("t3_rd8", bif.sysRAM_data, 128'h8);

        // T4 priority: UART beats system on the same line, one beat
        bif.uart2sys_en   = 1'b1;
        bif.uart2sys_data = 128'hA5A5;
        bif.sys_wren      = 1'b1;
        bif.sys_data      = 128'hBEEF;
        cycle("t4_both");
        idle_inputs();
        cycle("t4_idle");
        chk("t4_rd", bif.sysRAM_data, 128'hA5A5);

        // T5 program lane 3 of line 0x28 over a known line
        bif.uart2sys_en   = 1'b1;
        bif.uart2sys_addr = 20'h00028;
        bif.uart2sys_data = {$urandom, $urandom, $urandom, $urandom};
        cycle("t5_init");
        old_line = bif.uart2sys_data;
        idle_inputs();
        bif.prog_wen       = 1'b1;
        bif.prog_waddr     = 22'h0000A3;
        bif.prog_wdata     = 32'hDEADBEEF;
        bif.sys_final_addr = 20'h00028;
        cycle("t5_prog");
        idle_inputs();
        cycle("t5_read");
        chk("t5_line", bif.sysRAM_data, {32'hDEADBEEF, old_line[95:0]});

        // T6 collision: read-first then new value
        bif.sys_final_addr = 20'h00002;
        cycle("t6_pre");
        bif.sys_wren = 1'b1;
        bif.sys_data = 128'h1234_5678;
        cycle("t6_coll");
        chk("t6_old", bif.sysRAM_data, 128'hA5A5);
        idle_inputs();
        cycle("t6_new");
        chk("t6_newval", bif.sysRAM_data, 128'h1234_5678);

        // Known contents for lines 0..7 before random traffic
        bif.sys_wren = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bif.sys_final_addr = 20'(i);
            bif.sys_data       = {$urandom, $urandom, $urandom, $urandom};
            cycle("init");
        end
        idle_inputs();

        // Randomized contention over lines 0..7
        for (int i = 0; i < 300; i++) begin
            bif.uart2sys_en    = ($urandom_range(0, 3) == 0);
            bif.sys_wren       = ($urandom_range(0, 2) == 0);
            bif.prog_wen       = ($urandom_range(0, 1) == 0);
            bif.uart2sys_addr  = 20'($urandom_range(0, 7));
            bif.sys_final_addr = 20'($urandom_range(0, 7));
            bif.prog_waddr     = 22'($urandom_range(0, 31));
            bif.uart2sys_data  = {$urandom, $urandom, $urandom, $urandom};
            bif.sys_data       = {$urandom, $urandom, $urandom, $urandom};
            bif.prog_wdata     = $urandom;
            cycle("rand");
        end
        idle_inputs();
        cycle("rand_end");

        // Reset asserted under a pending write: write discarded
        bif.sys_final_addr = 20'h00003;
        old_line           = model[20'h00003];
        bif.uart2sys_en    = 1'b1;
        bif.uart2sys_addr  = 20'h00003;
        bif.uart2sys_data  = ~old_line;
        #2 rst_b = 1'b0;
        #1 chk("rst_async_htrans", 128'(bif.biu_pad_htrans), '0);
        @(negedge clk);
        cycle("rst_wr");
        idle_inputs();
        rst_b = 1'b1;
        cycle("rst_rel");
        chk("rst_keep", bif.sysRAM_data, old_line);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
